// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receive path.
package i2s_pkg;

  localparam int unsigned I2S_DATA_WIDTH = 24;
  localparam int unsigned I2S_SLOT_WIDTH = 32;

  typedef enum logic [1:0] {
    HUNT,
    SHIFT,
    PAD
  } i2s_state_t;

  typedef struct packed {
    logic [I2S_DATA_WIDTH-1:0] left;
    logic [I2S_DATA_WIDTH-1:0] right;
  } i2s_frame_t;

endpackage

// File: rtl/recv_data_by_i2s_if.sv
// Stereo frame stream (valid/ready) leaving the I2S receiver.
interface recv_data_by_i2s_if #(
  parameter int unsigned DATA_WIDTH = i2s_pkg::I2S_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] out_left;
  logic [DATA_WIDTH-1:0] out_right;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_left,
    output out_right,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_left,
    input  out_right,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/i2s_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with registered level and edge strobes.
module i2s_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // level is the synced value one clk later, so rise/fall line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/recv_data_by_i2s.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA and emits one {left,right} frame per LRCLK period.
module recv_data_by_i2s
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = I2S_DATA_WIDTH,
  parameter int unsigned SLOT_WIDTH  = I2S_SLOT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bclk,
  input  logic                    lrclk,
  input  logic                    sdata,
  recv_data_by_i2s_if.master      bus,
  output logic                    overflow,
  output logic                    frame_err,
  output logic                    locked
);

  localparam int unsigned CW = $clog2(SLOT_WIDTH + 2);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] PAD_LIMIT = CW'(SLOT_WIDTH + 1);

  logic [1:0] rst_q;
  logic       rst_i;

  // asynchronous assert, synchronous release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_i = rst_q[1];

  logic brise, ws, sd;
  logic bclk_level, bclk_fall, lrclk_rise, lrclk_fall, sdata_rise, sdata_fall;
  logic unused_strobes;

  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .rst_n(rst_i), .pin(bclk),  .level(bclk_level), .rise(brise),      .fall(bclk_fall));
  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk(clk), .rst_n(rst_i), .pin(lrclk), .level(ws),         .rise(lrclk_rise), .fall(lrclk_fall));
  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(clk), .rst_n(rst_i), .pin(sdata), .level(sd),         .rise(sdata_rise), .fall(sdata_fall));

  assign unused_strobes = ^{bclk_level, bclk_fall, lrclk_rise, lrclk_fall, sdata_rise, sdata_fall};

  i2s_state_t            state;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         slot_cnt;
  logic                  chan;
  logic                  ws_prev;
  logic                  left_ok;
  logic [DATA_WIDTH-2:0] shreg;
  logic [DATA_WIDTH-1:0] left_hold;
  logic [DATA_WIDTH-1:0] word;
  logic                  ws_edge;
  logic                  commit;

  always_comb begin
    ws_edge = brise && (ws != ws_prev);
    word    = {shreg, sd};
    commit  = brise && (state == SHIFT) && !ws_edge && (bit_cnt == LAST_BIT) && chan && left_ok;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      slot_cnt  <= '0;
      chan      <= 1'b0;
      ws_prev   <= 1'b0;
      left_ok   <= 1'b0;
      shreg     <= '0;
      left_hold <= '0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (brise) begin
        ws_prev <= ws;
        case (state)
          HUNT: begin
            if (ws_edge) begin
              state   <= SHIFT;
              chan    <= ws;
              bit_cnt <= '0;
              locked  <= 1'b1;
            end
          end
          SHIFT: begin
            if (ws_edge) begin
              frame_err <= 1'b1;
              left_ok   <= 1'b0;
              chan      <= ws;
              bit_cnt   <= '0;
            end else begin
              shreg <= word[DATA_WIDTH-2:0];
              if (bit_cnt == LAST_BIT) begin
                state    <= PAD;
                slot_cnt <= '0;
                if (!chan) begin
                  left_hold <= word;
                  left_ok   <= 1'b1;
                end else begin
                  left_ok   <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
          PAD: begin
            if (ws_edge) begin
              state   <= SHIFT;
              chan    <= ws;
              bit_cnt <= '0;
            end else if (slot_cnt == PAD_LIMIT) begin
              frame_err <= 1'b1;
              state     <= HUNT;
              locked    <= 1'b0;
              left_ok   <= 1'b0;
            end else begin
              slot_cnt <= slot_cnt + CW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  logic [DATA_WIDTH-1:0] out_left_q, out_right_q;
  logic                  out_valid_q;

  // an accept in the commit cycle frees the slot, so the new frame replaces the old one
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (commit) begin
        if (!out_valid_q || bus.out_ready) begin
          out_left_q  <= left_hold;
          out_right_q <= word;
          out_valid_q <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_left  = out_left_q;
  assign bus.out_right = out_right_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_recv_data_by_i2s.sv
// Directed bench for recv_data_by_i2s: drives an I2S sender model and checks frames and pulses.
module tb_recv_data_by_i2s;
  import i2s_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic bclk  = 1'b0;
  logic lrclk = 1'b0;
  logic sdata = 1'b0;
  logic overflow, frame_err, locked;

  recv_data_by_i2s_if #(.DATA_WIDTH(I2S_DATA_WIDTH)) bus ();

  recv_data_by_i2s #(
    .DATA_WIDTH (I2S_DATA_WIDTH),
    .SLOT_WIDTH (I2S_SLOT_WIDTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .bus      (bus),
    .overflow (overflow),
    .frame_err(frame_err),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned n_ovf = 0;
  int unsigned n_err = 0;
  logic [47:0] acc_q[$];

  always @(posedge clk) begin
    if (overflow)  n_ovf++;
    if (frame_err) n_err++;
    if (bus.out_valid && bus.out_ready) acc_q.push_back({bus.out_left, bus.out_right});
  end

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] acc_at(input int unsigned i);
    return (acc_q.size() > i) ? acc_q[i] : '1;
  endfunction

  task automatic send_bit(input logic ws, input logic b);
    bclk  = 1'b0;
    lrclk = ws;
    sdata = b;
    #40;
    bclk  = 1'b1;
    #40;
  endtask

  // delay bit, nbits data MSB first, then slot padding when the word is whole
  task automatic send_slot(input logic ws, input logic [23:0] w, input int unsigned nbits);
    send_bit(ws, 1'b0);
    for (int unsigned i = 0; i < nbits; i++) send_bit(ws, w[23-i]);
    if (nbits == 24) for (int unsigned i = 0; i < 7; i++) send_bit(ws, 1'b0);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, l, 24);
    send_slot(1'b1, r, 24);
  endtask

  task automatic clear_counts();
    n_ovf = 0;
    n_err = 0;
    acc_q.delete();
  endtask

  initial begin
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_valid",  {47'd0, bus.out_valid}, 48'd0);
    check_eq("rst_data",   {bus.out_left, bus.out_right}, 48'd0);
    check_eq("rst_flags",  {45'd0, locked, overflow, frame_err}, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // loopback: first left slot precedes lock, so two of three frames come out
    clear_counts();
    repeat (3) send_frame(24'hA5A5A5, 24'h5A5A5A);
    #100;
    check_eq("t1_count",  48'(acc_q.size()), 48'd2);
    check_eq("t1_frame0", acc_at(0), {24'hA5A5A5, 24'h5A5A5A});
    check_eq("t1_frame1", acc_at(1), {24'hA5A5A5, 24'h5A5A5A});
    check_eq("t1_errs",   48'(n_err + n_ovf), 48'd0);
    check_eq("t1_locked", {47'd0, locked}, 48'd1);

    // backpressure: first frame held, the next two dropped
    clear_counts();
    bus.out_ready = 1'b0;
    send_frame(24'h000001, 24'h000001);
    send_frame(24'h000002, 24'h000002);
    send_frame(24'h000003, 24'h000003);
    #100;
    check_eq("t2_ovf",    48'(n_ovf), 48'd2);
    check_eq("t2_valid",  {47'd0, bus.out_valid}, 48'd1);
    check_eq("t2_held",   {bus.out_left, bus.out_right}, {24'h000001, 24'h000001});
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t2_count",  48'(acc_q.size()), 48'd1);
    check_eq("t2_frame",  acc_at(0), {24'h000001, 24'h000001});
    check_eq("t2_vclear", {47'd0, bus.out_valid}, 48'd0);

    // LRCLK cuts a left word after 10 bits
    clear_counts();
    send_slot(1'b0, 24'hFFFFFF, 10);
    send_slot(1'b1, 24'h777777, 24);
    send_frame(24'h123456, 24'h654321);
    #100;
    check_eq("t3_err",    48'(n_err), 48'd1);
    check_eq("t3_count",  48'(acc_q.size()), 48'd1);
    check_eq("t3_frame",  acc_at(0), {24'h123456, 24'h654321});

    // LRCLK stalls high: seven pad BCLKs already counted, timeout on the 27th extra
    clear_counts();
    for (int unsigned k = 0; k < 26; k++) send_bit(1'b1, 1'b0);
    #20;
    check_eq("t4_no_err_yet", 48'(n_err), 48'd0);
    check_eq("t4_still_lock", {47'd0, locked}, 48'd1);
    send_bit(1'b1, 1'b0);
    #20;
    check_eq("t4_err",    48'(n_err), 48'd1);
    check_eq("t4_unlock", {47'd0, locked}, 48'd0);
    clear_counts();
    send_frame(24'h0F0F0F, 24'hF0F0F0);
    send_frame(24'h0F0F0F, 24'hF0F0F0);
    #100;
    check_eq("t4_relock", {47'd0, locked}, 48'd1);
    check_eq("t4_count",  48'(acc_q.size()), 48'd2);
    check_eq("t4_frame",  acc_at(1), {24'h0F0F0F, 24'hF0F0F0});
    check_eq("t4_errs",   48'(n_err), 48'd0);

    // reset mid-word with a frame pending
    clear_counts();
    bus.out_ready = 1'b0;
    send_frame(24'h111111, 24'h222222);
    check_eq("t5_pending", {47'd0, bus.out_valid}, 48'd1);
    send_slot(1'b0, 24'hC3C3C3, 12);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_valid", {47'd0, bus.out_valid}, 48'd0);
    check_eq("t5_async_data",  {bus.out_left, bus.out_right}, 48'd0);
    check_eq("t5_async_lock",  {47'd0, locked}, 48'd0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 19; i++) send_bit(1'b0, 1'b1);
    send_slot(1'b1, 24'h999999, 24);
    send_frame(24'h333333, 24'h444444);
    send_frame(24'h333333, 24'h444444);
    #100;
    check_eq("t5_count",  48'(acc_q.size()), 48'd2);
    check_eq("t5_frame0", acc_at(0), {24'h333333, 24'h444444});
    check_eq("t5_frame1", acc_at(1), {24'h333333, 24'h444444});

    // accept lands in the same clk as the next commit
    clear_counts();
    bus.out_ready = 1'b0;
    send_frame(24'h0000AA, 24'h0000BB);
    send_slot(1'b0, 24'h0000CC, 24);
    send_bit(1'b1, 1'b0);
    for (int unsigned i = 0; i < 23; i++) send_bit(1'b1, 1'b0);
    fork
      send_bit(1'b1, 1'b1);
      begin
        #70 bus.out_ready = 1'b1;
        #10 bus.out_ready = 1'b0;
      end
    join
    for (int unsigned i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    #100;
    check_eq("t6_count1", 48'(acc_q.size()), 48'd1);
    check_eq("t6_old",    acc_at(0), {24'h0000AA, 24'h0000BB});
    check_eq("t6_valid",  {47'd0, bus.out_valid}, 48'd1);
    check_eq("t6_new",    {bus.out_left, bus.out_right}, {24'h0000CC, 24'h000001});
    check_eq("t6_no_ovf", 48'(n_ovf), 48'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_count2", 48'(acc_q.size()), 48'd2);
    check_eq("t6_drain",  acc_at(1), {24'h0000CC, 24'h000001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
